// File: rtl/palindrome_rr_sched.sv
// Round-robin front end sharing one mirrored-bit-pair palindrome checker among
// NUM_REQ requesters; results come back tagged with the requester index.
module palindrome_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8,
  parameter int LEN_W   = $clog2(WORD_W + 1),
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*WORD_W-1:0]   req_word_i,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len_i,
  output logic                        resp_valid_o,
  output logic [ID_W-1:0]             resp_id_o,
  output logic                        resp_palindrome_o,
  input  logic                        resp_ready_i,
  output logic                        busy_o
);

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]   id_reg, id_next;
  logic [WORD_W-1:0] word_reg, word_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [LEN_W-1:0]  idx_reg, idx_next;
  logic              result_reg, result_next;

  // Rotate the valid vector so that bit 0 is the requester at rr_ptr.
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic                 grant_any;
  logic [ID_W-1:0]      grant_off;
  logic [ID_W:0]        win_sum;
  logic [ID_W-1:0]      winner;
  logic                 grant_en;

  assign valid_dbl = {req_valid_i, req_valid_i} >> rr_ptr_reg;
  assign valid_rot = valid_dbl[NUM_REQ-1:0];

  always_comb begin
    grant_any = 1'b0;
    grant_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        grant_any = 1'b1;
        grant_off = ID_W'(k);
      end
    end
  end

  assign win_sum  = {1'b0, rr_ptr_reg} + {1'b0, grant_off};
  assign winner   = (win_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(win_sum - (ID_W+1)'(NUM_REQ))
                                                    : win_sum[ID_W-1:0];
  // Ready is suppressed during reset so no requester sees a phantom handshake.
  assign grant_en = (state_reg == IDLE) && grant_any && !reset;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready_o[gi] = grant_en && (winner == ID_W'(gi));
    end
  endgenerate

  logic [WORD_W-1:0] sel_word;
  logic [LEN_W-1:0]  sel_len;
  logic [LEN_W-1:0]  len_clamped;

  assign sel_word    = req_word_i[winner*WORD_W +: WORD_W];
  assign sel_len     = req_len_i[winner*LEN_W +: LEN_W];
  assign len_clamped = (sel_len > LEN_W'(WORD_W)) ? LEN_W'(WORD_W) : sel_len;

  // Mirrored pair for the current index; i < L/2 keeps L-1-i in range.
  logic [WORD_W-1:0] shift_lo, shift_hi;
  logic [LEN_W-1:0]  half_m1;
  logic              pair_match, last_pair;

  assign shift_lo   = word_reg >> idx_reg;
  assign shift_hi   = word_reg >> (len_reg - LEN_W'(1) - idx_reg);
  assign pair_match = (shift_lo[0] == shift_hi[0]);
  assign half_m1    = (len_reg >> 1) - LEN_W'(1);
  assign last_pair  = (idx_reg == half_m1);

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    id_next     = id_reg;
    word_next   = word_reg;
    len_next    = len_reg;
    idx_next    = idx_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (grant_en) begin
          id_next   = winner;
          word_next = sel_word;
          len_next  = len_clamped;
          idx_next  = '0;
          if (len_clamped < LEN_W'(2)) begin
            result_next = 1'b1;
            state_next  = RESP;
          end else begin
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        if (!pair_match) begin
          result_next = 1'b0;
          state_next  = RESP;
        end else if (last_pair) begin
          result_next = 1'b1;
          state_next  = RESP;
        end else begin
          idx_next = idx_reg + LEN_W'(1);
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          rr_ptr_next = (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + ID_W'(1);
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      id_reg     <= '0;
      word_reg   <= '0;
      len_reg    <= '0;
      idx_reg    <= '0;
      result_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      id_reg     <= id_next;
      word_reg   <= word_next;
      len_reg    <= len_next;
      idx_reg    <= idx_next;
      result_reg <= result_next;
    end
  end

  assign resp_valid_o      = (state_reg == RESP);
  assign resp_id_o         = id_reg;
  assign resp_palindrome_o = result_reg;
  assign busy_o            = (state_reg != IDLE);

endmodule

// File: tb/tb_palindrome_rr_sched.sv
// Directed bench for palindrome_rr_sched: stimulus pushes expected tagged
// results into a queue, an independent monitor pops and compares them.
module tb_palindrome_rr_sched;

  localparam int NR = 4;
  localparam int WW = 8;
  localparam int LW = 4;
  localparam int IW = 2;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*WW-1:0] req_word;
  logic [NR*LW-1:0] req_len;
  logic             resp_valid;
  logic [IW-1:0]    resp_id;
  logic             resp_pal;
  logic             resp_ready;
  logic             busy;

  palindrome_rr_sched #(.NUM_REQ(NR), .WORD_W(WW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_word_i       (req_word),
    .req_len_i        (req_len),
    .resp_valid_o     (resp_valid),
    .resp_id_o        (resp_id),
    .resp_palindrome_o(resp_pal),
    .resp_ready_i     (resp_ready),
    .busy_o           (busy)
  );

  typedef struct {
    int id;
    int pal;
    int hs;
    int k;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int r, input logic [WW-1:0] w, input logic [LW-1:0] l);
    req_word[r*WW +: WW] = w;
    req_len[r*LW +: LW]  = l;
    req_valid[r]         = 1'b1;
  endtask

  // Wait for requester r to be granted, record the expected response, drop valid.
  task automatic wait_grant(input int r, input int pal, input int k);
    int n;
    exp_t e;
    #1;
    for (n = 0; n < 60; n++) begin
      if (req_ready[r]) break;
      @(negedge clk); #1;
    end
    check($sformatf("grant_req%0d_timeout", r), (n < 60) ? 1 : 0, 1);
    e.id = r; e.pal = pal; e.hs = cyc; e.k = k;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic issue(input int r, input logic [WW-1:0] w, input logic [LW-1:0] l,
                       input int pal, input int k);
    set_req(r, w, l);
    wait_grant(r, pal, k);
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 100; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_timeout", sb.size(), 0);
    @(negedge clk); @(negedge clk); #1;
  endtask

  // Monitor: samples after the stimulus has settled on each falling edge.
  logic          prev_v;
  logic [IW-1:0] prev_id;
  logic          prev_pal;
  initial begin
    exp_t e;
    prev_v = 1'b0; prev_id = '0; prev_pal = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        check("ready_onehot0", int'($onehot0(req_ready)), 1);
        if (busy) check("ready_while_busy", int'(req_ready), 0);
        if (resp_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_resp_id", int'(resp_id), -1);
          end else begin
            if (!prev_v) check($sformatf("latency_id%0d", sb[0].id), cyc - sb[0].hs, 1 + sb[0].k);
            else begin
              check("hold_id", int'(resp_id), int'(prev_id));
              check("hold_pal", int'(resp_pal), int'(prev_pal));
            end
            if (resp_ready) begin
              e = sb.pop_front();
              check("resp_id", int'(resp_id), e.id);
              check("resp_pal", int'(resp_pal), e.pal);
              $display("resp id=%0d pal=%0d at cycle %0d", resp_id, resp_pal, cyc);
            end
          end
        end
        prev_v   = resp_valid && !resp_ready;
        prev_id  = resp_id;
        prev_pal = resp_pal;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    int n, r, prev_hs;
    exp_t e;
    reset = 1'b1; resp_ready = 1'b1;
    req_valid = '0; req_word = '0; req_len = '0;

    // All four requesters valid from reset with L=1.
    for (int q = 0; q < NR; q++) set_req(q, WW'(q * 37), LW'(1));
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_resp_valid", int'(resp_valid), 0);
    check("reset_ready", int'(req_ready), 0);
    check("reset_resp_id", int'(resp_id), 0);
    check("reset_resp_pal", int'(resp_pal), 0);
    reset = 1'b0;
    #1;
    prev_hs = 0;
    for (int g = 0; g < 5; g++) begin
      for (n = 0; n < 20; n++) begin
        if (|req_ready) break;
        @(negedge clk); #1;
      end
      check("rr_grant_timeout", (n < 20) ? 1 : 0, 1);
      r = -1;
      for (int q = 0; q < NR; q++) if (req_ready[q]) r = q;
      check($sformatf("rr_grant_order%0d", g), r, order[g]);
      if (g > 0) check("rr_spacing", cyc - prev_hs, 2);
      prev_hs = cyc;
      e.id = r; e.pal = 1; e.hs = cyc; e.k = 0;
      sb.push_back(e);
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();

    // 8-bit palindrome, four pairs.
    issue(0, 8'b1010_0101, 4'd8, 1, 4);
    drain();
    // Early mismatch on the first pair.
    issue(2, 8'b0000_0110, 4'd3, 0, 1);
    drain();

    // Clamped length with a 3-cycle consumer stall.
    resp_ready = 1'b0;
    issue(1, 8'hFF, 4'd12, 1, 4);
    set_req(2, 8'h00, 4'd0);
    for (n = 0; n < 20; n++) begin
      if (resp_valid) break;
      @(negedge clk); #1;
    end
    check("stall_resp_timeout", (n < 20) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
    #1;
    resp_ready = 1'b1;
    @(negedge clk); #1;
    check("idle_after_accept", int'(busy), 0);
    wait_grant(2, 1, 0);
    drain();

    // Zero length and a 2-bit non-palindrome.
    issue(0, 8'h00, 4'd0, 1, 0);
    drain();
    issue(1, 8'b0000_0010, 4'd2, 0, 1);
    drain();

    // Reset during CHECK discards the job and returns rr_ptr to 0.
    set_req(3, 8'b1000_0001, 4'd8);
    #1;
    for (n = 0; n < 20; n++) begin
      if (req_ready[3]) break;
      @(negedge clk); #1;
    end
    check("abort_grant_timeout", (n < 20) ? 1 : 0, 1);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_resp_valid", int'(resp_valid), 0);
    set_req(0, 8'h3C, 4'd8);
    set_req(3, 8'b1000_0001, 4'd8);
    #1;
    check("post_reset_winner", int'(req_ready), 1);
    wait_grant(0, 1, 4);
    wait_grant(3, 1, 4);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
